// File: rtl/m2_block_scheduler.sv
// Milestone 2 IDCT block sequencer: walks the Y/U/V 8x8 blocks and overlaps
// fetch/compute/write engines, steering the shared SRAM port between FS and WS.
module m2_block_scheduler #(
  parameter int unsigned Y_COLS  = 40,
  parameter int unsigned UV_COLS = 20,
  parameter int unsigned ROWS    = 30,
  parameter int unsigned PRE_Y   = 76800,
  parameter int unsigned PRE_U   = 153600,
  parameter int unsigned PRE_V   = 192000,
  parameter int unsigned POST_Y  = 0,
  parameter int unsigned POST_U  = 38400,
  parameter int unsigned POST_V  = 57600
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Enable,
  input  logic        fs_done,
  input  logic        ct_done,
  input  logic        cs_done,
  input  logic        ws_done,
  output logic        fs_start,
  output logic        ct_start,
  output logic        cs_start,
  output logic        ws_start,
  output logic [17:0] fs_base_addr,
  output logic [17:0] ws_base_addr,
  output logic        ws_is_y,
  output logic        sram_sel_ws,
  output logic        busy,
  output logic        done,
  output logic        protocol_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LI_FS, S_LI_CT, S_A, S_B, S_LO_CS, S_LO_WS
  } state_t;

  typedef struct packed {
    logic [1:0] plane;
    logic [7:0] row;
    logic [7:0] col;
  } cursor_t;

  localparam logic [17:0] PY  = 18'(PRE_Y);
  localparam logic [17:0] PU  = 18'(PRE_U);
  localparam logic [17:0] PV  = 18'(PRE_V);
  localparam logic [17:0] QY  = 18'(POST_Y);
  localparam logic [17:0] QU  = 18'(POST_U);
  localparam logic [17:0] QV  = 18'(POST_V);
  localparam logic [7:0]  YCL = 8'(Y_COLS - 1);
  localparam logic [7:0]  UCL = 8'(UV_COLS - 1);
  localparam logic [7:0]  RL  = 8'(ROWS - 1);

  function automatic cursor_t next_cur(input cursor_t c);
    cursor_t r;
    r = c;
    if (c.col == ((c.plane == 2'd0) ? YCL : UCL)) begin
      r.col = '0;
      if (c.row == RL) begin
        r.row   = '0;
        r.plane = (c.plane == 2'd2) ? 2'd0 : c.plane + 2'd1;
      end else begin
        r.row = c.row + 8'd1;
      end
    end else begin
      r.col = c.col + 8'd1;
    end
    return r;
  endfunction

  function automatic logic is_last(input cursor_t c);
    return (c.plane == 2'd2) && (c.row == RL) && (c.col == UCL);
  endfunction

  // Pre-IDCT block origin: row*8*pitch + col*8 with pitch 320 (Y) or 160 (U/V)
  function automatic logic [17:0] pre_addr(input cursor_t c);
    logic [17:0] r, k;
    r = 18'(c.row);
    k = 18'(c.col);
    case (c.plane)
      2'd0:    return PY + (r << 11) + (r << 9) + (k << 3);
      2'd1:    return PU + (r << 10) + (r << 8) + (k << 3);
      default: return PV + (r << 10) + (r << 8) + (k << 3);
    endcase
  endfunction

  // Post-IDCT block origin: row*8*pitch + col*4 with pitch 160 (Y) or 80 (U/V)
  function automatic logic [17:0] post_addr(input cursor_t c);
    logic [17:0] r, k;
    r = 18'(c.row);
    k = 18'(c.col);
    case (c.plane)
      2'd0:    return QY + (r << 10) + (r << 8) + (k << 2);
      2'd1:    return QU + (r << 9) + (r << 7) + (k << 2);
      default: return QV + (r << 9) + (r << 7) + (k << 2);
    endcase
  endfunction

  state_t     state, state_n;
  logic       entry;
  logic [3:0] run, got, dn, acc, bad;
  logic       all_done, start_frame, fetched_all;
  cursor_t    fcur, wcur, fcur_n, wcur_n;

  assign dn          = {fs_done, ct_done, cs_done, ws_done};
  assign start_frame = (state == S_IDLE) && Enable;

  always_comb begin
    run = 4'b0000;
    case (state)
      S_LI_FS: run = 4'b1000;
      S_LI_CT: run = 4'b0100;
      S_A:     run = 4'b1010;
      S_B:     run = 4'b0101;
      S_LO_CS: run = 4'b0010;
      S_LO_WS: run = 4'b0001;
      default: run = 4'b0000;
    endcase
  end

  // A done in the start cycle, from an idle engine, or repeated is rejected
  assign acc      = dn & run & ~got & {4{~entry}};
  assign bad      = dn & ~acc;
  assign all_done = (state != S_IDLE) && (((got | acc) & run) == run);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (Enable)   state_n = S_LI_FS;
      S_LI_FS: if (all_done) state_n = S_LI_CT;
      S_LI_CT: if (all_done) state_n = S_A;
      S_A:     if (all_done) state_n = S_B;
      S_B:     if (all_done) state_n = fetched_all ? S_LO_CS : S_A;
      S_LO_CS: if (all_done) state_n = S_LO_WS;
      S_LO_WS: if (all_done) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    fcur_n = fcur;
    wcur_n = wcur;
    if (start_frame) begin
      fcur_n = '0;
      wcur_n = '0;
    end else begin
      if (acc[3]) fcur_n = next_cur(fcur);
      if (acc[0]) wcur_n = next_cur(wcur);
    end
  end

  assign {fs_start, ct_start, cs_start, ws_start} = entry ? run : 4'b0000;
  assign sram_sel_ws = (state == S_B) || (state == S_LO_WS);
  assign busy        = (state != S_IDLE);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state        <= S_IDLE;
      entry        <= 1'b0;
      got          <= '0;
      protocol_err <= 1'b0;
      done         <= 1'b0;
      fcur         <= '0;
      wcur         <= '0;
      fetched_all  <= 1'b0;
      fs_base_addr <= '0;
      ws_base_addr <= '0;
      ws_is_y      <= 1'b0;
    end else begin
      state        <= state_n;
      entry        <= (state_n != state) && (state_n != S_IDLE);
      got          <= (state_n != state) ? 4'b0000 : (got | acc);
      protocol_err <= protocol_err | (|bad);
      done         <= (state == S_LO_WS) && (state_n == S_IDLE);
      fcur         <= fcur_n;
      wcur         <= wcur_n;
      if (start_frame)
        fetched_all <= 1'b0;
      else if (acc[3] && is_last(fcur))
        fetched_all <= 1'b1;
      // Addresses follow the post-advance cursor so the next start already sees them
      fs_base_addr <= pre_addr(fcur_n);
      ws_base_addr <= post_addr(wcur_n);
      ws_is_y      <= (wcur_n.plane == 2'd0);
    end
  end

endmodule

// File: tb/tb_m2_block_scheduler.sv
// Directed bench for m2_block_scheduler: small-frame state trace, default-frame
// address log, done-ordering, protocol-error and mid-frame reset cases.
module tb_m2_block_scheduler;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // small-parameter instance
  logic        s_en = 1'b0;
  logic [3:0]  s_done = '0;
  logic [3:0]  s_code;
  logic [17:0] s_fsa, s_wsa;
  logic        s_isy, s_sel, s_busy, s_doneo, s_perr;

  // default-parameter instance
  logic        d_en = 1'b0;
  logic [3:0]  d_done = '0;
  logic [3:0]  d_code;
  logic [17:0] d_fsa, d_wsa;
  logic        d_isy, d_sel, d_busy, d_doneo, d_perr;
  logic        d_auto = 1'b0;

  always #5 Clock = ~Clock;

  m2_block_scheduler #(.Y_COLS(2), .UV_COLS(1), .ROWS(1)) u_small (
    .Clock(Clock), .Resetn(Resetn), .Enable(s_en),
    .fs_done(s_done[3]), .ct_done(s_done[2]), .cs_done(s_done[1]), .ws_done(s_done[0]),
    .fs_start(s_code[3]), .ct_start(s_code[2]), .cs_start(s_code[1]), .ws_start(s_code[0]),
    .fs_base_addr(s_fsa), .ws_base_addr(s_wsa), .ws_is_y(s_isy), .sram_sel_ws(s_sel),
    .busy(s_busy), .done(s_doneo), .protocol_err(s_perr)
  );

  m2_block_scheduler u_dut (
    .Clock(Clock), .Resetn(Resetn), .Enable(d_en),
    .fs_done(d_done[3]), .ct_done(d_done[2]), .cs_done(d_done[1]), .ws_done(d_done[0]),
    .fs_start(d_code[3]), .ct_start(d_code[2]), .cs_start(d_code[1]), .ws_start(d_code[0]),
    .fs_base_addr(d_fsa), .ws_base_addr(d_wsa), .ws_is_y(d_isy), .sram_sel_ws(d_sel),
    .busy(d_busy), .done(d_doneo), .protocol_err(d_perr)
  );

  // Engine stand-in: done pulse 5 cycles after each start it sees
  task automatic engine(input int k, input bit big);
    forever begin
      @(negedge Clock);
      while (big ? (d_auto && d_code[k]) : s_code[k]) begin
        repeat (5) @(negedge Clock);
        if (big) d_done[k] = 1'b1; else s_done[k] = 1'b1;
        @(negedge Clock);
        if (big) d_done[k] = 1'b0; else s_done[k] = 1'b0;
      end
    end
  endtask

  initial engine(3, 1'b0);
  initial engine(2, 1'b0);
  initial engine(1, 1'b0);
  initial engine(0, 1'b0);
  initial engine(3, 1'b1);
  initial engine(2, 1'b1);
  initial engine(1, 1'b1);
  initial engine(0, 1'b1);

  logic [3:0]  s_tr [0:15];
  int          s_tn = 0;
  int          s_dc = 0;
  logic [17:0] fs_log [0:2399];
  logic [17:0] ws_log [0:2399];
  logic        wy_log [0:2399];
  int          fn = 0;
  int          wn = 0;
  int          d_dc = 0;

  initial begin
    forever begin
      @(negedge Clock);
      if (|s_code) begin
        if (s_tn < 16) s_tr[s_tn] = s_code;
        s_tn++;
      end
      if (s_doneo) s_dc++;
      if (d_auto && d_code[3]) begin
        if (fn < 2400) fs_log[fn] = d_fsa;
        fn++;
      end
      if (d_auto && d_code[0]) begin
        if (wn < 2400) begin
          ws_log[wn] = d_wsa;
          wy_log[wn] = d_isy;
        end
        wn++;
      end
      if (d_auto && d_doneo) d_dc++;
    end
  end

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive a done set for one cycle; return at the negedge after it was sampled
  task pulse_d(input logic [3:0] m);
    @(negedge Clock);
    d_done = m;
    @(negedge Clock);
    d_done = '0;
  endtask

  logic [3:0] exp_tr [0:9];
  bit         found;

  initial begin
    exp_tr = '{4'b1000, 4'b0100, 4'b1010, 4'b0101, 4'b1010,
               4'b0101, 4'b1010, 4'b0101, 4'b0010, 4'b0001};

    #12;
    chk("rst_busy", {31'd0, d_busy}, 32'd0);
    chk("rst_starts", {28'd0, d_code}, 32'd0);
    chk("rst_fsa", {14'd0, d_fsa}, 32'd0);
    chk("rst_wsa", {14'd0, d_wsa}, 32'd0);
    chk("rst_misc", {28'd0, d_isy, d_sel, d_doneo, d_perr}, 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;

    // small frame: 4 blocks, auto-responding engines
    @(negedge Clock);
    s_en = 1'b1;
    @(negedge Clock);
    s_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge Clock);
      if (s_dc != 0) found = 1'b1;
    end
    chk("small_finish", {31'd0, found}, 32'd1);
    repeat (3) @(negedge Clock);
    chk("small_states", s_tn, 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("small_trace%0d", i), {28'd0, s_tr[i]}, {28'd0, exp_tr[i]});
    chk("small_done_cnt", s_dc, 1);
    chk("small_idle", {30'd0, s_busy, s_perr}, 32'd0);

    // default frame with address logging
    d_auto = 1'b1;
    @(negedge Clock);
    d_en = 1'b1;
    @(negedge Clock);
    d_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40000 && !found; i++) begin
      @(negedge Clock);
      if (d_dc != 0) found = 1'b1;
    end
    chk("frame_finish", {31'd0, found}, 32'd1);
    repeat (8) @(negedge Clock);
    d_auto = 1'b0;
    chk("frame_fs_cnt", fn, 2400);
    chk("frame_ws_cnt", wn, 2400);
    chk("frame_perr", {31'd0, d_perr}, 32'd0);
    chk("y_r1c39_fs", {14'd0, fs_log[79]}, 32'd79672);
    chk("y_r1c39_ws", {14'd0, ws_log[79]}, 32'd1436);
    chk("y_r1c39_isy", {31'd0, wy_log[79]}, 32'd1);
    chk("u_first_fs", {14'd0, fs_log[1200]}, 32'd153600);
    chk("u_first_ws", {14'd0, ws_log[1200]}, 32'd38400);
    chk("u_first_isy", {31'd0, wy_log[1200]}, 32'd0);
    chk("v_last_fs", {14'd0, fs_log[2399]}, 32'd229272);
    chk("v_last_ws", {14'd0, ws_log[2399]}, 32'd76236);

    // manual engine replies
    @(negedge Clock);
    d_en = 1'b1;
    @(negedge Clock);
    d_en = 1'b0;
    chk("en_to_lifs", {27'd0, d_busy, d_code}, 32'b11000);
    pulse_d(4'b1000);
    chk("li_ct_start", {28'd0, d_code}, 32'b0100);
    pulse_d(4'b0100);
    chk("a1_start", {28'd0, d_code}, 32'b1010);
    chk("a1_fsa", {14'd0, d_fsa}, 32'd76808);

    pulse_d(4'b0010);
    chk("a1_cs_only", {28'd0, d_code}, 32'd0);
    repeat (8) @(negedge Clock);
    chk("a1_still_a", {30'd0, d_busy, d_sel}, 32'b10);
    pulse_d(4'b1000);
    chk("a1_exit_fs_late", {27'd0, d_sel, d_code}, 32'b10101);
    chk("b1_wsa", {14'd0, d_wsa}, 32'd0);

    pulse_d(4'b0101);
    chk("a2_start", {28'd0, d_code}, 32'b1010);
    chk("a2_fsa", {14'd0, d_fsa}, 32'd76816);
    pulse_d(4'b1000);
    repeat (8) @(negedge Clock);
    chk("a2_still_a", {28'd0, d_code}, 32'd0);
    pulse_d(4'b0010);
    chk("a2_exit_cs_late", {27'd0, d_sel, d_code}, 32'b10101);
    chk("b2_wsa", {14'd0, d_wsa}, 32'd4);

    pulse_d(4'b0101);
    pulse_d(4'b1010);
    chk("a3_simul_exit", {28'd0, d_code}, 32'b0101);
    chk("a3_no_perr", {31'd0, d_perr}, 32'd0);

    // asynchronous reset in B
    #2;
    chk("pre_rst_b", {30'd0, d_busy, d_sel}, 32'b11);
    Resetn = 1'b0;
    #1;
    chk("midrst_ctl", {25'd0, d_busy, d_sel, d_doneo, d_code}, 32'd0);
    chk("midrst_addr", {d_wsa[13:0], d_fsa}, 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    d_en = 1'b1;
    @(negedge Clock);
    d_en = 1'b0;
    chk("restart_fs", {28'd0, d_code}, 32'b1000);
    chk("restart_fsa", {14'd0, d_fsa}, 32'd76800);

    // stray ws_done in LI_CT, Enable while busy
    pulse_d(4'b1000);
    chk("li_ct_again", {28'd0, d_code}, 32'b0100);
    pulse_d(4'b0001);
    chk("stray_perr", {31'd0, d_perr}, 32'd1);
    @(negedge Clock);
    d_en = 1'b1;
    @(negedge Clock);
    d_en = 1'b0;
    chk("busy_enable", {27'd0, d_busy, d_code}, 32'b10000);
    pulse_d(4'b0100);
    chk("after_stray_a", {28'd0, d_code}, 32'b1010);
    pulse_d(4'b1010);
    chk("wcur_unchanged", {14'd0, d_wsa}, 32'd0);
    chk("wcur_isy", {31'd0, d_isy}, 32'd1);
    chk("perr_sticky", {31'd0, d_perr}, 32'd1);
    #2;
    Resetn = 1'b0;
    #1;
    chk("perr_cleared", {31'd0, d_perr}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
